// File: rtl/pc_redirect_if.sv
// Fetch-PC redirect bus: pipeline redirect requests in, fetch PC, flushes and
// mispredict statistics out.
interface pc_redirect_if #(
   parameter int unsigned CNT_W = 16
);
   logic             stall;
   logic             pred_taken;
   logic [12:0]      pred_pc;
   logic             d_valid;
   logic             d_fail;
   logic [12:0]      d_true_pc;
   logic             e_valid;
   logic             e_fail;
   logic [12:0]      e_true_pc;
   logic [12:0]      fetch_pc;
   logic             flush_f;
   logic             flush_d;
   logic             recovering;
   logic [CNT_W-1:0] d_miss_cnt;
   logic [CNT_W-1:0] e_miss_cnt;

   modport master (
      output stall, pred_taken, pred_pc, d_valid, d_fail, d_true_pc,
             e_valid, e_fail, e_true_pc,
      input  fetch_pc, flush_f, flush_d, recovering, d_miss_cnt, e_miss_cnt
   );

   modport slave (
      input  stall, pred_taken, pred_pc, d_valid, d_fail, d_true_pc,
             e_valid, e_fail, e_true_pc,
      output fetch_pc, flush_f, flush_d, recovering, d_miss_cnt, e_miss_cnt
   );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC sequencer for the dual-issue front end: arbitrates E/D redirects,
// predictor and sequential PC, issues flushes and masks wrong-path D redirects.
module pc_redirect_ctrl #(
   parameter logic [12:0] RESET_PC       = 13'h0000,
   parameter int unsigned FETCH_STEP     = 2,
   parameter int unsigned RECOVER_CYCLES = 1,
   parameter int unsigned CNT_W          = 16
) (
   input logic          clk,
   input logic          rst_n,
   pc_redirect_if.slave bus
);
   typedef enum logic {
      RUN     = 1'b0,
      RECOVER = 1'b1
   } state_t;

   localparam logic [12:0]      STEP     = 13'(FETCH_STEP);
   localparam logic [2:0]       REC_LOAD = 3'(RECOVER_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_t           state_r;
   logic [2:0]       rec_cnt_r;
   logic [12:0]      fetch_pc_r;
   logic [CNT_W-1:0] d_cnt_r;
   logic [CNT_W-1:0] e_cnt_r;
   logic             e_acc_s;
   logic             d_acc_s;
   logic [12:0]      next_pc_s;

   // Accept terms and next-PC priority: E redirect, D redirect, stall, predictor, sequential.
   always_comb begin
      e_acc_s   = bus.e_valid & bus.e_fail;
      d_acc_s   = bus.d_valid & bus.d_fail & ~e_acc_s & ~bus.stall & (state_r == RUN);
      next_pc_s = fetch_pc_r + STEP;
      if (e_acc_s) begin
         next_pc_s = bus.e_true_pc;
      end else if (d_acc_s) begin
         next_pc_s = bus.d_true_pc;
      end else if (bus.stall) begin
         next_pc_s = fetch_pc_r;
      end else if (bus.pred_taken) begin
         next_pc_s = bus.pred_pc;
      end else begin
         next_pc_s = fetch_pc_r + STEP;
      end
   end

   // Fetch PC, RUN/RECOVER sequencing and saturating mispredict counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_r <= RESET_PC;
         state_r    <= RUN;
         rec_cnt_r  <= 3'd0;
         d_cnt_r    <= {CNT_W{1'b0}};
         e_cnt_r    <= {CNT_W{1'b0}};
      end else begin
         fetch_pc_r <= next_pc_s;
         case (state_r)
            RUN: begin
               if (e_acc_s || d_acc_s) begin
                  state_r   <= RECOVER;
                  rec_cnt_r <= REC_LOAD;
               end else begin
                  state_r   <= RUN;
                  rec_cnt_r <= 3'd0;
               end
            end
            RECOVER: begin
               // A stall freezes the recovery window along with the D stage.
               if (e_acc_s) begin
                  rec_cnt_r <= REC_LOAD;
               end else if (!bus.stall) begin
                  rec_cnt_r <= rec_cnt_r - 3'd1;
                  if (rec_cnt_r <= 3'd1) begin
                     state_r <= RUN;
                  end else begin
                     state_r <= RECOVER;
                  end
               end else begin
                  rec_cnt_r <= rec_cnt_r;
               end
            end
            default: begin
               state_r   <= RUN;
               rec_cnt_r <= 3'd0;
            end
         endcase
         if (e_acc_s && (e_cnt_r != CNT_MAX)) begin
            e_cnt_r <= e_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            e_cnt_r <= e_cnt_r;
         end
         if (d_acc_s && (d_cnt_r != CNT_MAX)) begin
            d_cnt_r <= d_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            d_cnt_r <= d_cnt_r;
         end
      end
   end

   // Flushes fire in the accept cycle so the wrong-path bundles die at the next edge.
   assign bus.flush_f    = rst_n & (e_acc_s | d_acc_s);
   assign bus.flush_d    = rst_n & e_acc_s;
   assign bus.fetch_pc   = fetch_pc_r;
   assign bus.recovering = (state_r == RECOVER);
   assign bus.d_miss_cnt = d_cnt_r;
   assign bus.e_miss_cnt = e_cnt_r;
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: a rule-level model checked every cycle,
// plus literal expectations at the interesting points of the sequence.
module tb_pc_redirect_ctrl;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = 15;
   localparam int REC_CYC = 1;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   pc_redirect_if #(.CNT_W(CNT_W)) bus ();

   pc_redirect_ctrl #(
      .RESET_PC      (13'h0000),
      .FETCH_STEP    (2),
      .RECOVER_CYCLES(REC_CYC),
      .CNT_W         (CNT_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: architectural view of PC, recovery window and counters.
   int m_pc;
   bit m_rec;
   int m_left;
   int m_d;
   int m_e;

   function automatic bit f_eacc();
      return bus.e_valid && bus.e_fail;
   endfunction

   function automatic bit f_dacc();
      return bus.d_valid && bus.d_fail && !f_eacc() && !bus.stall && !m_rec;
   endfunction

   function automatic int f_next_pc();
      if (f_eacc())       return int'(bus.e_true_pc);
      if (f_dacc())       return int'(bus.d_true_pc);
      if (bus.stall)      return m_pc;
      if (bus.pred_taken) return int'(bus.pred_pc);
      return (m_pc + 2) % 8192;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc   <= 0;
         m_rec  <= 1'b0;
         m_left <= 0;
         m_d    <= 0;
         m_e    <= 0;
      end else begin
         m_pc <= f_next_pc();
         if (f_eacc() || f_dacc()) begin
            m_rec  <= 1'b1;
            m_left <= REC_CYC;
         end else if (m_rec && !bus.stall) begin
            m_left <= m_left - 1;
            m_rec  <= (m_left > 1);
         end
         if (f_eacc()) m_e <= (m_e < CNT_MAX) ? m_e + 1 : m_e;
         if (f_dacc()) m_d <= (m_d < CNT_MAX) ? m_d + 1 : m_d;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("m_fetch_pc", int'(bus.fetch_pc), m_pc);
      chk("m_recovering", int'(bus.recovering), int'(m_rec));
      chk("m_d_miss_cnt", int'(bus.d_miss_cnt), m_d);
      chk("m_e_miss_cnt", int'(bus.e_miss_cnt), m_e);
      chk("m_flush_f", int'(bus.flush_f), int'(rst_n && (f_eacc() || f_dacc())));
      chk("m_flush_d", int'(bus.flush_d), int'(rst_n && f_eacc()));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.stall      = 1'b0;
      bus.pred_taken = 1'b0;
      bus.pred_pc    = 13'h0000;
      bus.d_valid    = 1'b0;
      bus.d_fail     = 1'b0;
      bus.d_true_pc  = 13'h0000;
      bus.e_valid    = 1'b0;
      bus.e_fail     = 1'b0;
      bus.e_true_pc  = 13'h0000;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      idle_inputs();
      rst_n = 1'b0;
      bus.e_valid   = 1'b1;
      bus.e_fail    = 1'b1;
      bus.e_true_pc = 13'h0123;
      #1;
      chk("rst_flush_f", int'(bus.flush_f), 0);
      chk("rst_flush_d", int'(bus.flush_d), 0);
      chk("rst_fetch_pc", int'(bus.fetch_pc), 'h000);
      chk("rst_recovering", int'(bus.recovering), 0);
      tick();
      tick();
      chk("rst_hold_pc", int'(bus.fetch_pc), 'h000);
      idle_inputs();
      rst_n = 1'b1;
      #1;
      chk("run_pc0", int'(bus.fetch_pc), 'h000);
      tick(); chk("run_pc1", int'(bus.fetch_pc), 'h002);
      tick(); chk("run_pc2", int'(bus.fetch_pc), 'h004);
      tick(); chk("run_pc3", int'(bus.fetch_pc), 'h006);
      chk("run_flush_f", int'(bus.flush_f), 0);
      chk("run_recovering", int'(bus.recovering), 0);

      // Predictor hit, then D jal redirect that also overrides a predictor hit.
      bus.pred_taken = 1'b1; bus.pred_pc = 13'h0010;
      tick(); chk("pred_pc", int'(bus.fetch_pc), 'h010);
      bus.pred_pc   = 13'h0555;
      bus.d_valid   = 1'b1; bus.d_fail = 1'b1; bus.d_true_pc = 13'h0040;
      #1;
      chk("d_flush_f", int'(bus.flush_f), 1);
      chk("d_flush_d", int'(bus.flush_d), 0);
      tick();
      chk("d_pc", int'(bus.fetch_pc), 'h040);
      chk("d_recovering", int'(bus.recovering), 1);
      chk("d_cnt1", int'(bus.d_miss_cnt), 1);
      idle_inputs();
      tick();
      chk("d_rec_done", int'(bus.recovering), 0);
      chk("d_seq_pc", int'(bus.fetch_pc), 'h042);

      // Simultaneous E and D: E wins.
      bus.e_valid = 1'b1; bus.e_fail = 1'b1; bus.e_true_pc = 13'h0100;
      bus.d_valid = 1'b1; bus.d_fail = 1'b1; bus.d_true_pc = 13'h0040;
      #1;
      chk("ed_flush_f", int'(bus.flush_f), 1);
      chk("ed_flush_d", int'(bus.flush_d), 1);
      tick();
      chk("ed_pc", int'(bus.fetch_pc), 'h100);
      chk("ed_e_cnt", int'(bus.e_miss_cnt), 1);
      chk("ed_d_cnt", int'(bus.d_miss_cnt), 1);
      bus.e_valid = 1'b0; bus.e_fail = 1'b0; bus.d_true_pc = 13'h0080;
      #1;
      chk("rec_d_masked", int'(bus.flush_f), 0);
      tick();
      chk("rec_pc", int'(bus.fetch_pc), 'h102);
      chk("rec_d_cnt", int'(bus.d_miss_cnt), 1);

      // D redirect deferred by stall, accepted on release.
      bus.stall = 1'b1; bus.pred_taken = 1'b1; bus.pred_pc = 13'h0777;
      #1;
      chk("stall_no_flush", int'(bus.flush_f), 0);
      tick();
      chk("stall_hold_pc", int'(bus.fetch_pc), 'h102);
      bus.stall = 1'b0;
      #1;
      chk("unstall_flush_f", int'(bus.flush_f), 1);
      tick();
      chk("unstall_pc", int'(bus.fetch_pc), 'h080);
      chk("unstall_d_cnt", int'(bus.d_miss_cnt), 2);
      idle_inputs();
      bus.stall = 1'b1;
      tick();
      chk("rec_stall_pc", int'(bus.fetch_pc), 'h080);
      chk("rec_stall_held", int'(bus.recovering), 1);
      bus.stall = 1'b0;
      tick();
      chk("rec_stall_pc2", int'(bus.fetch_pc), 'h082);
      chk("rec_stall_done", int'(bus.recovering), 0);

      // E redirect overrides stall; then sequential wrap at the top of the PC space.
      bus.stall = 1'b1;
      bus.e_valid = 1'b1; bus.e_fail = 1'b1; bus.e_true_pc = 13'h1FFF;
      #1;
      chk("e_stall_flush_d", int'(bus.flush_d), 1);
      tick();
      chk("e_stall_pc", int'(bus.fetch_pc), 'h1FFF);
      chk("e_stall_cnt", int'(bus.e_miss_cnt), 2);
      idle_inputs();
      tick();
      chk("wrap_pc", int'(bus.fetch_pc), 'h0001);

      // Back-to-back E redirects keep RECOVER alive.
      bus.e_valid = 1'b1; bus.e_fail = 1'b1; bus.e_true_pc = 13'h0200;
      tick(); chk("ee_pc1", int'(bus.fetch_pc), 'h200);
      bus.e_true_pc = 13'h0300;
      tick();
      chk("ee_pc2", int'(bus.fetch_pc), 'h300);
      chk("ee_rec", int'(bus.recovering), 1);
      chk("ee_cnt", int'(bus.e_miss_cnt), 4);
      idle_inputs();
      tick();
      chk("ee_rec_done", int'(bus.recovering), 0);
      chk("ee_seq_pc", int'(bus.fetch_pc), 'h302);

      // Saturate the E counter.
      bus.e_valid = 1'b1; bus.e_fail = 1'b1;
      for (int i = 0; i < 15; i++) begin
         bus.e_true_pc = 13'(i * 4);
         tick();
      end
      chk("e_cnt_sat", int'(bus.e_miss_cnt), 15);
      tick();
      chk("e_cnt_sat_hold", int'(bus.e_miss_cnt), 15);
      idle_inputs();
      tick();

      // Asynchronous reset in the middle of RECOVER.
      bus.e_valid = 1'b1; bus.e_fail = 1'b1; bus.e_true_pc = 13'h00AA;
      tick();
      chk("mid_rec", int'(bus.recovering), 1);
      idle_inputs();
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_pc", int'(bus.fetch_pc), 'h000);
      chk("mid_rst_rec", int'(bus.recovering), 0);
      chk("mid_rst_ecnt", int'(bus.e_miss_cnt), 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_pc", int'(bus.fetch_pc), 'h002);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Sequences the fetch PC for the dual-issue front end.
- Arbitrates among three sources of the next fetch PC:
  - E-stage mispredict redirect (jalr/branch resolution);
  - D-stage jal redirect (the fail_predict/true_pc pair from D-stage PC calculation);
  - F-stage predictor target, or the sequential PC.
- Generates F/D flush pulses, runs a short recovery state machine that masks wrong-path D redirects, and keeps saturating mispredict counters.
- Sits between the F-stage PC register and the D/E PC-calculation blocks.

Parameters:
- RESET_PC, 13'h0000, fetch word address loaded on reset.
- FETCH_STEP, 2, words advanced per sequential fetch (two instructions per bundle).
- RECOVER_CYCLES, 1, cycles in RECOVER after an accepted redirect (1..7).
- CNT_W, 16, width of each mispredict counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hazard stall; hold the F and D stages.
- pred_taken  in  1  F-stage predictor hit (taken).
- pred_pc  in  13  F-stage predicted target.
- d_valid  in  1  D stage holds a live bundle.
- d_fail  in  1  D-stage jal mispredict.
- d_true_pc  in  13  D-stage computed jal target.
- e_valid  in  1  E stage holds a live instruction.
- e_fail  in  1  E-stage jalr/branch mispredict.
- e_true_pc  in  13  E-stage resolved target.
- fetch_pc  out  13  registered current fetch PC.
- flush_f  out  1  kill the F→D bundle at the next edge.
- flush_d  out  1  kill the D→E bundle at the next edge.
- recovering  out  1  high while state is RECOVER.
- d_miss_cnt  out  CNT_W  accepted D redirects, saturating.
- e_miss_cnt  out  CNT_W  accepted E redirects, saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - fetch_pc = RESET_PC; state = RUN; recover counter = 0; both miss counters = 0.
  - flush_f and flush_d are forced 0 while rst_n is low.
- Accept terms (combinational):
  - e_acc = e_valid & e_fail.
  - d_acc = d_valid & d_fail & ~e_acc & ~stall & (state==RUN).
- Next fetch_pc, in priority order (registered, 1-cycle latency):
  1. e_acc: e_true_pc.
  2. d_acc: d_true_pc.
  3. stall: hold.
  4. pred_taken: pred_pc.
  5. Otherwise: fetch_pc + FETCH_STEP, modulo 2^13 (wraps 13'h1FFF+2 → 13'h0001).
- E redirect overrides stall. A D redirect during stall is deferred; the stalled D bundle re-presents it.
- Flushes (combinational, same cycle as accept):
  - e_acc: flush_f = flush_d = 1.
  - d_acc: flush_f = 1, flush_d = 0.
  - Otherwise both 0.
- State machine, RUN / RECOVER:
  - RUN → RECOVER on e_acc or d_acc; recover counter loads RECOVER_CYCLES.
  - In RECOVER, the counter decrements each non-stall cycle; RECOVER → RUN when the counter reaches 0 on that cycle's edge.
  - In RECOVER, D redirects are ignored because D holds wrong-path or bubble contents.
  - In RECOVER, e_acc is still honoured, reloads the counter and stays in RECOVER.
  - recovering = (state==RECOVER).
- Counters:
  - d_miss_cnt increments on d_acc; e_miss_cnt increments on e_acc.
  - Each saturates at all-ones; no wrap.
- Simultaneous e_acc & d_acc: E wins because it is the older instruction. Only e_miss_cnt increments; the D request is discarded.
- Reset asserted mid-RECOVER: immediate return to RUN with fetch_pc = RESET_PC.
- pred_taken is ignored whenever any redirect is accepted.

Test Plan:
- Reset then 3 free-run cycles → fetch_pc 0x000, 0x002, 0x004, 0x006; no flushes; recovering = 0.
- At fetch_pc 0x010, d_valid = d_fail = 1, d_true_pc = 0x040 → same cycle flush_f = 1, flush_d = 0; next fetch_pc = 0x040; recovering = 1 for 1 cycle; d_miss_cnt = 1.
- Same cycle: e_fail/e_valid with e_true_pc = 0x100 and d_fail with d_true_pc = 0x040 → flush_f = flush_d = 1; fetch_pc = 0x100; e_miss_cnt = 1, d_miss_cnt unchanged.
- The cycle after the E redirect, assert d_fail with d_true_pc = 0x080 → ignored (RECOVER); fetch_pc = 0x102; no flush.
- stall = 1 with d_fail pending → fetch_pc held and no flush. Release stall with d_fail still high → redirect accepted that cycle.
- fetch_pc = 0x1FFF sequential → next 0x0001. Preload e_miss_cnt to 0xFFFF and accept an E redirect → counter stays 0xFFFF.
